// File: rtl/datapath_pipe.sv
// Five-stage (F/D/E/M/W) datapath with hazard unit and data-memory port.
// Define DATAPATH_FWD_EN to build E-stage forwarding; otherwise RAW hazards stall F/D.
module datapath_pipe #(
    parameter int DATA_W = 24,
    parameter int PC_W   = 16,
    parameter int NREG   = 16,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instF,
    output logic [PC_W-1:0]   pcF,
    output logic [DATA_W-1:0] instD,
    input  logic              regWriteD,
    input  logic              memToRegD,
    input  logic              memWriteD,
    input  logic              aluSrcD,
    input  logic              branchD,
    input  logic              ra1SrcD,
    input  logic              ra2SrcD,
    input  logic              immSrcD,
    input  logic [1:0]        aluControlD,
    output logic [PC_W-1:0]   dataAddrM,
    output logic [DATA_W-1:0] dataWDataM,
    output logic              dataWeM,
    input  logic [DATA_W-1:0] dataRDataM,
    output logic [DATA_W-1:0] resultW,
    output logic [RA_W-1:0]   wa3W,
    output logic              regWriteW,
    output logic              zeroE,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE
);

    // D stage
    logic              validD;
    logic [RA_W-1:0]   ra1D, ra2D, wa3D;
    logic [DATA_W-1:0] immD, rd1D, rd2D;
    logic [DATA_W-1:0] rf [NREG];

    // E stage
    logic              validE, regWriteE, memToRegE, memWriteE, aluSrcE, branchE;
    logic [1:0]        aluControlE;
    logic [DATA_W-1:0] rd1E, rd2E, immE;
    logic [RA_W-1:0]   wa3E;
    logic [DATA_W-1:0] fwdA, fwdB, srcB, aluResultE;

    // M stage
    logic              regWriteM, memToRegM, memWriteM;
    logic [DATA_W-1:0] aluResultM, storeDataM;
    logic [RA_W-1:0]   wa3M;

    // W stage
    logic              memToRegW;
    logic [DATA_W-1:0] aluResultW, readDataW;

    logic hazard, taken;

`ifdef DATAPATH_FWD_EN
    logic [RA_W-1:0] ra1E, ra2E;
`endif

    assign wa3D = instD[16 +: RA_W];
    assign ra1D = ra1SrcD ? instD[16 +: RA_W] : instD[12 +: RA_W];
    assign ra2D = ra2SrcD ? instD[16 +: RA_W] : instD[8 +: RA_W];
    assign immD = immSrcD ? {{(DATA_W-12){instD[11]}}, instD[11:0]}
                          : {{(DATA_W-12){1'b0}}, instD[11:0]};

    always_ff @(posedge clk) begin
        if (regWriteW)
            rf[wa3W] <= resultW;
    end

    // Write-first: a read of the register being written this cycle sees resultW.
    always_comb begin
        rd1D = (regWriteW && wa3W == ra1D) ? resultW : rf[ra1D];
        rd2D = (regWriteW && wa3W == ra2D) ? resultW : rf[ra2D];
    end

    always_comb begin
        hazard = validE && memToRegE && (wa3E == ra1D || wa3E == ra2D);
`ifndef DATAPATH_FWD_EN
        if (regWriteE && (wa3E == ra1D || wa3E == ra2D))
            hazard = 1'b1;
        if (regWriteM && (wa3M == ra1D || wa3M == ra2D))
            hazard = 1'b1;
`endif
        taken  = branchE && validE;
        stallF = hazard && !taken;
        stallD = hazard && !taken;
        flushD = taken;
        flushE = hazard || taken;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pcF <= '0;
        else if (taken)
            pcF <= aluResultE[PC_W-1:0];
        else if (!stallF)
            pcF <= pcF + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            instD  <= '0;
            validD <= 1'b0;
        end else if (!stallD) begin
            instD  <= instF;
            validD <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            validE      <= 1'b0;
            regWriteE   <= 1'b0;
            memToRegE   <= 1'b0;
            memWriteE   <= 1'b0;
            aluSrcE     <= 1'b0;
            branchE     <= 1'b0;
            aluControlE <= '0;
            rd1E        <= '0;
            rd2E        <= '0;
            immE        <= '0;
            wa3E        <= '0;
`ifdef DATAPATH_FWD_EN
            ra1E        <= '0;
            ra2E        <= '0;
`endif
        end else begin
            validE      <= validD;
            regWriteE   <= regWriteD && validD;
            memToRegE   <= memToRegD;
            memWriteE   <= memWriteD && validD;
            aluSrcE     <= aluSrcD;
            branchE     <= branchD && validD;
            aluControlE <= aluControlD;
            rd1E        <= rd1D;
            rd2E        <= rd2D;
            immE        <= immD;
            wa3E        <= wa3D;
`ifdef DATAPATH_FWD_EN
            ra1E        <= ra1D;
            ra2E        <= ra2D;
`endif
        end
    end

`ifdef DATAPATH_FWD_EN
    always_comb begin
        fwdA = rd1E;
        if (regWriteM && wa3M == ra1E)
            fwdA = aluResultM;
        else if (regWriteW && wa3W == ra1E)
            fwdA = resultW;
        fwdB = rd2E;
        if (regWriteM && wa3M == ra2E)
            fwdB = aluResultM;
        else if (regWriteW && wa3W == ra2E)
            fwdB = resultW;
    end
`else
    assign fwdA = rd1E;
    assign fwdB = rd2E;
`endif

    assign srcB = aluSrcE ? immE : fwdB;

    always_comb begin
        case (aluControlE)
            2'b00:   aluResultE = fwdA + srcB;
            2'b01:   aluResultE = fwdA - srcB;
            2'b10:   aluResultE = fwdA & srcB;
            default: aluResultE = fwdA | srcB;
        endcase
    end

    assign zeroE = validE && (aluResultE == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            regWriteM  <= 1'b0;
            memToRegM  <= 1'b0;
            memWriteM  <= 1'b0;
            aluResultM <= '0;
            storeDataM <= '0;
            wa3M       <= '0;
        end else begin
            regWriteM  <= regWriteE;
            memToRegM  <= memToRegE;
            memWriteM  <= memWriteE;
            aluResultM <= aluResultE;
            storeDataM <= fwdB;
            wa3M       <= wa3E;
        end
    end

    // A store sitting in M is squashed the moment reset is raised.
    assign dataAddrM  = aluResultM[PC_W-1:0];
    assign dataWDataM = storeDataM;
    assign dataWeM    = memWriteM && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            regWriteW  <= 1'b0;
            memToRegW  <= 1'b0;
            aluResultW <= '0;
            readDataW  <= '0;
            wa3W       <= '0;
        end else begin
            regWriteW  <= regWriteM;
            memToRegW  <= memToRegM;
            aluResultW <= aluResultM;
            readDataW  <= dataRDataM;
            wa3W       <= wa3M;
        end
    end

    assign resultW = memToRegW ? readDataW : aluResultW;

endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised five-stage (F/D/E/M/W) processor datapath, successor of the three-stage datapath. It adds internal E/M/W pipeline registers, data-memory ports, a hazard unit (load-use stall, taken-branch flush) and E-stage operand forwarding. Decode control is external and combinational from `instD`. It sits between the instruction ROM and data RAM, both with combinational reads, and the control unit.

## Interface
- `DATA_W`, 24, datapath/register width
- `PC_W`, 16, PC and memory-address width (≤ DATA_W)
- `NREG`, 16, register count; address width `RA_W = $clog2(NREG)` (4 at default)
- `clk` in 1, rising-edge clock
- `rst` in 1, reset: one clock, synchronous, active-high
- `instF` in DATA_W, instruction read at `pcF`
- `pcF` out PC_W, fetch address
- `instD` out DATA_W, decode-stage instruction, to control unit
- `regWriteD, memToRegD, memWriteD, aluSrcD, branchD, ra1SrcD, ra2SrcD, immSrcD` in 1 each, decode control
- `aluControlD` in 2, 00 add, 01 sub, 10 and, 11 or
- `dataAddrM` out PC_W, `dataWDataM` out DATA_W, `dataWeM` out 1, data-memory port
- `dataRDataM` in DATA_W, combinational read data
- `resultW` out DATA_W, `wa3W` out RA_W, `regWriteW` out 1, writeback
- `zeroE` out 1, ALU zero flag
- `stallF, stallD, flushD, flushE` out 1 each, hazard-unit status

## Operation
- Fields: `wa3 = inst[19:16]`. `ra1 = ra1Src ? inst[19:16] : inst[15:12]`. `ra2 = ra2Src ? inst[19:16] : inst[11:8]`. imm = `inst[11:0]`, sign-extended when `immSrc`=1 and zero-extended otherwise, to DATA_W.
- Register file: NREG×DATA_W, written on the clock edge in W when `regWriteW`. Reads are combinational with write-first bypass: a read of the address being written in W returns `resultW`.
- Each stage register carries a valid bit. A bubble (valid=0) forces regWrite/memWrite/branch to 0.
- E: srcB = aluSrcE ? immE : fwdB. ALU is DATA_W wide, and carry-out is dropped. `zeroE` = (result == 0) and validE.
- Forwarding (per operand, E stage), in priority order:
  - if regWriteM and wa3M == raE, take aluResultM;
  - else if regWriteW and wa3W == raE, take resultW;
  - else the register-file value.
  - fwdB is also the store data.
- M: `dataAddrM = aluResultM[PC_W-1:0]`, `dataWeM = memWriteM`, `dataWDataM = storeDataM`.
- W: `resultW = memToRegW ? readDataW : aluResultW`.
- Load-use: memToRegE, validE, and (wa3E == ra1D or wa3E == ra2D) together cause a stall. stallF=stallD=1 and flushE=1 (a bubble is inserted into E) for exactly one cycle.
- Branch: branchE and validE is a taken branch. pcF ← aluResultE[PC_W-1:0] on the next edge, and flushD=flushE=1. The penalty is 2 cycles.
- A taken branch overrides a simultaneous load-use stall: the F/D stall is dropped and both D and E are flushed.
- PC otherwise advances by +1 and wraps modulo 2^PC_W.

## Timing
- Reset (synchronous): pcF=0; all valid bits 0; all pipeline registers 0. Consequently dataWeM=0, regWriteW=0, resultW=0, wa3W=0, zeroE=0, instD=0, and all stall/flush outputs=0. The register file is not cleared.
- First fetch at pcF=0 occurs in the cycle after `rst` deasserts. `rst` asserted mid-operation squashes all in-flight instructions at that edge. No memory write happens after that edge.
- Latency: an instruction in F at cycle n writes back at the edge ending cycle n+4, with no stalls.
- Throughput: 1 instruction per cycle, except the load-use stall (1 cycle) and a taken branch (2 cycles).
- Hazard outputs are combinational in the same cycle as the condition.

## Configuration
- `DATAPATH_FWD_EN` defined: forwarding muxes are present as described.
- `DATAPATH_FWD_EN` undefined: no forwarding, and E always uses register-file values.
  - The hazard unit instead stalls F/D and bubbles E while a D source matches the wa3 of a valid regWrite instruction in E or M.
  - This is up to 2 stall cycles; W is covered by the write-first bypass.
  - Branch behaviour is unchanged.

## Test plan
- Reset: hold rst 2 cycles mid-program with a store in M → dataWeM=0 at once, pcF=0, and the instruction at address 0 reaches D two cycles after release.
- Forwarding (FWD_EN): R1←5, R2←R1+3, R3←R2−8 back-to-back → resultW 5, 8, 0 on consecutive cycles; zeroE=1 for the third; no stall asserted.
- Load-use: LDR R4,[addr 0x10] (memory=0x00ABCD), then ADD R5,R4,1 → exactly one stall cycle (stallF=stallD=flushE=1 once); R5=0x00ABCE.
- Branch: branch to 0x0020 at PC 0x0005 → flushD=flushE=1 for one cycle; the instructions at 0x0006/0x0007 never write; pcF=0x0020 next cycle.
- Branch plus load-use in the same cycle → no stall, pcF=target, both younger instructions squashed.
- FWD disabled: the same three-instruction RAW chain → two stall cycles per dependence, identical final register values.
